// File: rtl/rx_mag_acc.sv
`default_nettype none
// ============================================================================
//  Module   : rx_mag_acc
//  Purpose  : Streaming I/Q magnitude estimator with windowed averaging and
//             threshold detect for the receive path (AGC, energy/carrier
//             detect). Three registered stages compute
//             |I+jQ| ~= max + f(min), with f selected per sample by mode.
//             The estimate is then averaged over 2^P_ACC_LOG2 valid samples.
//  Ports    : clk     - system clock
//             rst_n   - asynchronous active-low reset
//             in_vld  - data_i/data_q/mode valid this cycle
//             data_i  - in-phase sample, signed, P_W bits
//             data_q  - quadrature sample, signed, P_W bits
//             mode    - approximation select, travels with the sample
//             clr     - synchronous flush of the pipeline and the window
//             thr     - detect threshold, sampled when a window completes
//             mag_vld - per-sample estimate valid
//             mag     - per-sample estimate, unsigned P_W+1 bits (held)
//             avg_vld - one-cycle pulse when a window completes
//             avg     - window average, unsigned P_W+1 bits (held)
//             det     - avg >= thr, updated with avg
//  Revision : 1.0 - initial release
// ============================================================================
module rx_mag_acc #(
  parameter int P_W        = 6,
  parameter int P_ACC_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  logic [P_W-1:0]      data_i,
  input  logic [P_W-1:0]      data_q,
  input  logic [1:0]          mode,
  input  logic                clr,
  input  logic [P_W:0]        thr,
  output logic                mag_vld,
  output logic [P_W:0]        mag,
  output logic                avg_vld,
  output logic [P_W:0]        avg,
  output logic                det
);

  localparam int             c_MW  = P_W + 1;
  localparam int             c_AW  = P_W + 1 + P_ACC_LOG2;
  localparam logic [P_W-1:0] c_ONE = {{(P_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Two's complement magnitude in P_W bits. The most negative code maps to
  // 2^(P_W-1), which is representable as an unsigned P_W-bit value.
  // --------------------------------------------------------------------------
  function automatic logic [P_W-1:0] f_abs(input logic [P_W-1:0] x);
    f_abs = x[P_W-1] ? (~x + c_ONE) : x;
  endfunction

  // Stage 1 registers
  logic           s1_vld_q, s1_vld_d;
  logic [P_W-1:0] abs_i_q, abs_i_d;
  logic [P_W-1:0] abs_q_q, abs_q_d;
  logic [1:0]     s1_mode_q, s1_mode_d;

  // Stage 2 registers
  logic           s2_vld_q, s2_vld_d;
  logic [P_W-1:0] big_q, big_d;
  logic [P_W-1:0] small_q, small_d;
  logic [1:0]     s2_mode_q, s2_mode_d;

  // Stage 3 registers
  logic           mag_vld_q, mag_vld_d;
  logic [c_MW-1:0] mag_q, mag_d;

  // Window accumulator
  logic [c_AW-1:0]       acc_q, acc_d;
  logic [P_ACC_LOG2-1:0] cnt_q, cnt_d;
  logic                  avg_vld_q, avg_vld_d;
  logic [c_MW-1:0]       avg_q, avg_d;
  logic                  det_q, det_d;

  // Combinational helpers
  logic [P_W-1:0]  f_small;
  logic [c_AW-1:0] acc_sum;
  logic [c_MW-1:0] avg_new;
  logic            win_last;

  // --------------------------------------------------------------------------
  // Stage 1: absolute values; mode is captured with the sample so a mode
  // change never reaches samples already in the pipeline.
  // --------------------------------------------------------------------------
  always_comb begin
    s1_vld_d  = in_vld & ~clr;
    abs_i_d   = abs_i_q;
    abs_q_d   = abs_q_q;
    s1_mode_d = s1_mode_q;
    if (in_vld) begin
      abs_i_d   = f_abs(data_i);
      abs_q_d   = f_abs(data_q);
      s1_mode_d = mode;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: sort into big/small; a tie keeps abs_i as big.
  // --------------------------------------------------------------------------
  always_comb begin
    s2_vld_d  = s1_vld_q & ~clr;
    big_d     = big_q;
    small_d   = small_q;
    s2_mode_d = s2_mode_q;
    if (s1_vld_q) begin
      s2_mode_d = s1_mode_q;
      if (abs_q_q > abs_i_q) begin
        big_d   = abs_q_q;
        small_d = abs_i_q;
      end else begin
        big_d   = abs_i_q;
        small_d = abs_q_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: mag = big + f(small). Every shift term is floored on its own;
  // the largest f is small/2, so the sum never exceeds P_W+1 bits.
  // --------------------------------------------------------------------------
  always_comb begin
    f_small = '0;
    case (s2_mode_q)
      2'd0:    f_small = (small_q >> 2) + (small_q >> 4) + (small_q >> 5);
      2'd1:    f_small = small_q >> 1;
      2'd2:    f_small = '0;
      default: f_small = (small_q >> 2) + (small_q >> 3);
    endcase
  end

  always_comb begin
    mag_vld_d = s2_vld_q & ~clr;
    mag_d     = mag_q;
    if (s2_vld_q && !clr) begin
      mag_d = {1'b0, big_q} + {1'b0, f_small};
    end
  end

  // --------------------------------------------------------------------------
  // Window accumulator. acc_sum already includes the current estimate so the
  // completing sample is part of its own window average.
  // --------------------------------------------------------------------------
  always_comb begin
    acc_sum  = acc_q + {{P_ACC_LOG2{1'b0}}, mag_q};
    avg_new  = acc_sum[c_AW-1:P_ACC_LOG2];
    win_last = &cnt_q;

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_vld_d = 1'b0;
    avg_d     = avg_q;
    det_d     = det_q;

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (mag_vld_q) begin
      cnt_d = cnt_q + 1'b1;  // wraps to 0 on the completing sample
      if (win_last) begin
        acc_d     = '0;
        avg_vld_d = 1'b1;
        avg_d     = avg_new;
        det_d     = (avg_new >= thr);
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      abs_i_q   <= '0;
      abs_q_q   <= '0;
      s1_mode_q <= '0;
      s2_vld_q  <= 1'b0;
      big_q     <= '0;
      small_q   <= '0;
      s2_mode_q <= '0;
      mag_vld_q <= 1'b0;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_vld_q <= 1'b0;
      avg_q     <= '0;
      det_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      abs_i_q   <= abs_i_d;
      abs_q_q   <= abs_q_d;
      s1_mode_q <= s1_mode_d;
      s2_vld_q  <= s2_vld_d;
      big_q     <= big_d;
      small_q   <= small_d;
      s2_mode_q <= s2_mode_d;
      mag_vld_q <= mag_vld_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_vld_q <= avg_vld_d;
      avg_q     <= avg_d;
      det_q     <= det_d;
    end
  end

  assign mag_vld = mag_vld_q;
  assign mag     = mag_q;
  assign avg_vld = avg_vld_q;
  assign avg     = avg_q;
  assign det     = det_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_mag_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_mag_acc
//  Purpose  : Scoreboard bench for rx_mag_acc. The driver pushes the
//             hand-computed estimate and arrival cycle of every sample it
//             sends, plus the expected average/detect of every window it
//             completes; a monitor pops and compares whenever the DUT raises
//             mag_vld or avg_vld.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_mag_acc;

  localparam int W = 6;
  localparam int L = 4;

  typedef struct {
    logic [W:0] v;
    int         cyc;
  } mag_exp_t;

  typedef struct {
    logic [W:0] v;
    logic       d;
    int         cyc;
  } avg_exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic [W-1:0] data_i = '0;
  logic [W-1:0] data_q = '0;
  logic [1:0]   mode = '0;
  logic         clr = 1'b0;
  logic [W:0]   thr = '0;
  logic         mag_vld;
  logic [W:0]   mag;
  logic         avg_vld;
  logic [W:0]   avg;
  logic         det;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_cyc = 0;

  mag_exp_t mag_sb[$];
  avg_exp_t avg_sb[$];

  rx_mag_acc #(.P_W(W), .P_ACC_LOG2(L)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .data_i  (data_i),
    .data_q  (data_q),
    .mode    (mode),
    .clr     (clr),
    .thr     (thr),
    .mag_vld (mag_vld),
    .mag     (mag),
    .avg_vld (avg_vld),
    .avg     (avg),
    .det     (det)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk = n_chk + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Monitor: compares every presented output against the scoreboard.
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mag_vld) begin
        if (mag_sb.size() == 0) begin
          chk("mag_unexpected", 1, 0);
        end else begin
          mag_exp_t e;
          e = mag_sb.pop_front();
          chk("mag_value", int'(mag), int'(e.v));
          chk("mag_cycle", cyc, e.cyc);
        end
      end
      if (avg_vld) begin
        if (avg_sb.size() == 0) begin
          chk("avg_unexpected", 1, 0);
        end else begin
          avg_exp_t a;
          a = avg_sb.pop_front();
          chk("avg_value", int'(avg), int'(a.v));
          chk("det_value", int'(det), int'(a.d));
          chk("avg_cycle", cyc, a.cyc);
        end
      end
    end
  end

  // Present one sample on the next capture edge; optionally record its
  // expected estimate (arrives three edges later).
  task automatic send(input logic [W-1:0] i, input logic [W-1:0] q,
                      input logic [1:0] m, input int exp_mag,
                      input bit push, input bit with_clr);
    mag_exp_t e;
    @(negedge clk);
    in_vld = 1'b1;
    data_i = i;
    data_q = q;
    mode   = m;
    clr    = with_clr;
    if (push) begin
      e.v = exp_mag[W:0];
      e.cyc = cyc + 3;
      last_cyc = e.cyc;
      mag_sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_vld = 1'b0;
      clr    = 1'b0;
    end
  endtask

  task automatic flush();
    @(negedge clk);
    in_vld = 1'b0;
    clr    = 1'b1;
    @(negedge clk);
    clr    = 1'b0;
  endtask

  task automatic push_avg(input int v, input bit d);
    avg_exp_t a;
    a.v = v[W:0];
    a.d = d;
    a.cyc = last_cyc + 1;
    avg_sb.push_back(a);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mag_vld", int'(mag_vld), 0);
    chk("rst_mag", int'(mag), 0);
    chk("rst_avg_vld", int'(avg_vld), 0);
    chk("rst_avg", int'(avg), 0);
    chk("rst_det", int'(det), 0);
    rst_n = 1'b1;
    idle(2);

    // Basic estimate: 20 + (12>>2) = 23
    send(6'd20, -6'sd12, 2'd0, 23, 1'b1, 1'b0);
    idle(6);

    // All modes at the negative extreme, then a tie
    send(-6'sd32, -6'sd32, 2'd0, 43, 1'b1, 1'b0);
    send(-6'sd32, -6'sd32, 2'd1, 48, 1'b1, 1'b0);
    send(-6'sd32, -6'sd32, 2'd2, 32, 1'b1, 1'b0);
    send(-6'sd32, -6'sd32, 2'd3, 44, 1'b1, 1'b0);
    send(6'd5, -6'sd5, 2'd1, 7, 1'b1, 1'b0);
    idle(6);

    // Window, thr = 10 -> det = 1
    flush();
    thr = 7'd10;
    for (int k = 0; k < 16; k++) send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
    push_avg(10, 1'b1);
    idle(6);

    // Window, thr = 11 -> det = 0; a 17th sample opens a new window
    thr = 7'd11;
    for (int k = 0; k < 16; k++) send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
    push_avg(10, 1'b0);
    send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
    idle(8);

    // Gapped input: only valid samples count
    flush();
    thr = 7'd10;
    for (int k = 0; k < 16; k++) begin
      send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
      idle(1);
    end
    push_avg(10, 1'b1);
    idle(6);

    // Flush: 7 samples, then 2 in flight plus one presented with clr
    flush();
    thr = 7'd11;
    for (int k = 0; k < 7; k++) send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
    idle(5);
    chk("mag_hold", int'(mag), 10);
    send(6'd20, 6'd0, 2'd0, 0, 1'b0, 1'b0);
    send(6'd20, 6'd0, 2'd0, 0, 1'b0, 1'b0);
    send(6'd20, 6'd0, 2'd0, 0, 1'b0, 1'b1);
    idle(6);
    chk("flush_avg_hold", int'(avg), 10);
    chk("flush_det_hold", int'(det), 1);
    chk("flush_mag_hold", int'(mag), 10);
    thr = 7'd8;
    for (int k = 0; k < 16; k++) send(6'd8, 6'd0, 2'd0, 8, 1'b1, 1'b0);
    push_avg(8, 1'b1);
    idle(6);

    // Async reset mid-window after 9 samples
    thr = 7'd10;
    for (int k = 0; k < 9; k++) send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
    idle(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mag", int'(mag), 0);
    chk("arst_avg", int'(avg), 0);
    chk("arst_det", int'(det), 0);
    chk("arst_mag_vld", int'(mag_vld), 0);
    chk("arst_avg_vld", int'(avg_vld), 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 15; k++) send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
    idle(6);
    chk("arst_no_early_avg", int'(avg), 0);
    send(6'd10, 6'd0, 2'd0, 10, 1'b1, 1'b0);
    push_avg(10, 1'b1);
    idle(8);

    chk("mag_sb_empty", mag_sb.size(), 0);
    chk("avg_sb_empty", avg_sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_mag_acc.md
Name: rx_mag_acc

Overview:
- Pipelined, parametrised I/Q magnitude estimator for the receive path.
- Estimates |I+jQ| with a runtime-selectable max/min approximation.
- Averages the estimate over a power-of-two window and flags when the average reaches a programmable threshold.
- Feeds AGC and energy/carrier detect; replaces the purely combinational estimator with a registered, streaming block.

Parameters:
- P_W, 6, I/Q input width (two's complement).
- P_ACC_LOG2, 4, log2 of the averaging window length; window = 2^P_ACC_LOG2 valid samples.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_vld  input  1  data_i/data_q/mode valid this cycle.
- data_i  input  P_W  in-phase sample, signed.
- data_q  input  P_W  quadrature sample, signed.
- mode  input  2  approximation select, sampled with in_vld.
- clr  input  1  synchronous flush of the pipeline and the window.
- thr  input  P_W+1  detect threshold, unsigned, sampled on the window-completion cycle.
- mag_vld  output  1  mag valid.
- mag  output  P_W+1  per-sample magnitude estimate, unsigned.
- avg_vld  output  1  one-cycle pulse when a window completes.
- avg  output  P_W+1  window average, unsigned.
- det  output  1  avg >= thr, updated with avg.

Behaviour:
- Reset (rst_n low, async): all pipeline valids, mag, avg, det, avg_vld, accumulator and sample count go to 0 immediately. Release is synchronous to clk.
- No backpressure. in_vld may have arbitrary gaps; only valid samples advance the window.
- Stage 1 (registered):
  - abs_i = |data_i| and abs_q = |data_q|, each unsigned P_W bits. -2^(P_W-1) maps to 2^(P_W-1), with no saturation.
  - mode is registered alongside the data and travels with the sample; changing mode never affects samples already in flight.
- Stage 2 (registered): big = max(abs_i, abs_q), small = min(abs_i, abs_q). On a tie, big = abs_i.
- Stage 3 (registered), mag = big + f(small), with each shift term floored independently:
  - mode 0: (small>>2) + (small>>4) + (small>>5)
  - mode 1: small>>1
  - mode 2: 0 (max only)
  - mode 3: (small>>2) + (small>>3)
- Result fits P_W+1 bits unsigned; no overflow is possible.
- Latency: a sample with in_vld=1 at rising edge n gives mag_vld=1 and its mag in the cycle after edge n+2 (3 registers). mag holds its value when mag_vld=0.
- Accumulator:
  - Width P_W+1+P_ACC_LOG2. Counter width P_ACC_LOG2.
  - On each mag_vld: acc += mag and cnt increments.
  - When mag_vld and cnt == 2^P_ACC_LOG2-1, at the next edge:
    - avg = (acc+mag) >> P_ACC_LOG2 (floor)
    - det = (that avg >= thr)
    - avg_vld = 1 for exactly one cycle
    - acc = 0, cnt wraps to 0
  - avg and det hold until the next window completes.
- clr=1 at an edge:
  - Clears all three stage valids, acc and cnt. Samples in flight are discarded.
  - A sample presented with in_vld in the same cycle as clr is discarded.
  - avg and det keep their last values; avg_vld is forced to 0.
- No other state. Back-to-back windows are continuous: sample 2^L+1 starts the next window with no dead cycle.

Test Plan:
- Basic estimate, mode 0, P_W=6: I=20, Q=-12, in_vld for one cycle -> exactly one mag_vld pulse, 3 cycles later, with mag=23 (20+3+0+0); no other mag_vld.
- Modes at the negative extreme: I=-32, Q=-32 sent with mode 0/1/2/3 on consecutive cycles -> mag=43, 48, 32, 44 on consecutive cycles. Also a tie check with I=5, Q=-5, mode 1 -> mag=7.
- Window and detect, P_ACC_LOG2=4: 16 samples of I=10, Q=0, mode 0, back-to-back:
  - thr=10 -> single avg_vld pulse one cycle after the 16th mag_vld, avg=10, det=1.
  - Repeat with thr=11 -> det=0.
  - A 17th sample starts a fresh window with no extra avg_vld.
- Gapped input: the same 16 samples with in_vld toggled 1/0 -> identical avg=10. avg_vld occurs only after the 16th valid sample; idle cycles are not counted.
- Flush:
  - Send 7 samples, then assert clr while 2 more samples are in flight and one more is presented with clr -> no avg_vld.
  - Then send 16 samples of mag 8 -> avg=8 exactly once.
  - Earlier avg/det values are held throughout.
- Async reset mid-window: after 9 samples, pulse rst_n low between clock edges -> mag, avg, det and all valids read 0 before the next edge. After release, a full 16-sample window is needed for avg_vld.
